// File: rtl/ws2812_matrix_driver.sv
// ws2812_matrix_driver: scans NUM_PIXELS pixels and serialises each as a GRB word on a WS2812 line.
// Define WS2812_DIM_EN to send every channel right-shifted by 2.
module ws2812_matrix_driver #(
    parameter int NUM_PIXELS   = 64,
    parameter int BIT_CYCLES   = 15,
    parameter int T0H_CYCLES   = 4,
    parameter int T1H_CYCLES   = 8,
    parameter int LATCH_CYCLES = 1200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] red_data,
    input  logic [7:0] green_data,
    input  logic [7:0] blue_data,
    output logic [5:0] pixel,
    output logic [4:0] frame,
    output logic       data_out,
    output logic       frame_done
);
    localparam int CW = $clog2((LATCH_CYCLES > BIT_CYCLES ? LATCH_CYCLES : BIT_CYCLES) + 1);
    typedef enum logic [1:0] {LATCH, FETCH0, FETCH1, SHIFT} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [23:0] shift_reg, shift_n, grb;
    logic [4:0] bit_idx, bit_idx_n;
    logic [5:0] pixel_n;
    logic [4:0] frame_n;
    logic data_out_n, frame_done_n;
`ifdef WS2812_DIM_EN
    assign grb = {2'b00, green_data[7:2], 2'b00, red_data[7:2], 2'b00, blue_data[7:2]};
`else
    assign grb = {green_data, red_data, blue_data};
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LATCH;
            cnt        <= '0;
            shift_reg  <= '0;
            bit_idx    <= '0;
            pixel      <= '0;
            frame      <= '0;
            data_out   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            shift_reg  <= shift_n;
            bit_idx    <= bit_idx_n;
            pixel      <= pixel_n;
            frame      <= frame_n;
            data_out   <= data_out_n;
            frame_done <= frame_done_n;
        end
    end
    always_comb begin
        state_n      = state;
        cnt_n        = cnt + CW'(1);
        shift_n      = shift_reg;
        bit_idx_n    = bit_idx;
        pixel_n      = pixel;
        frame_n      = frame;
        frame_done_n = 1'b0;
        case (state)
            LATCH: begin
                pixel_n = '0;
                if (cnt == CW'(LATCH_CYCLES - 1)) begin
                    state_n = FETCH0;
                    cnt_n   = '0;
                end
            end
            FETCH0: state_n = FETCH1;
            FETCH1: begin
                state_n   = SHIFT;
                cnt_n     = '0;
                shift_n   = grb;
                bit_idx_n = 5'd23;
            end
            default: begin
                if (cnt == CW'(BIT_CYCLES - 1)) begin
                    cnt_n     = '0;
                    shift_n   = {shift_reg[22:0], 1'b0};
                    bit_idx_n = bit_idx - 5'd1;
                    if (bit_idx == 5'd0) begin
                        state_n      = pixel < 6'(NUM_PIXELS - 1) ? FETCH0 : LATCH;
                        pixel_n      = pixel < 6'(NUM_PIXELS - 1) ? pixel + 6'd1 : 6'd0;
                        frame_n      = pixel < 6'(NUM_PIXELS - 1) ? frame : frame + 5'd1;
                        frame_done_n = !(pixel < 6'(NUM_PIXELS - 1));
                    end
                end
            end
        endcase
        // Registered line: the high phase is decided from the state and bit the next cycle will be in.
        data_out_n = state_n == SHIFT && cnt_n < (shift_n[23] ? CW'(T1H_CYCLES) : CW'(T0H_CYCLES));
    end
endmodule
